// File: rtl/regbank_wr_arb.sv
// regbank_wr_arb: round-robin write arbiter in front of a bank of enable-flop registers.
// NREQ clients each present {addr, data}. One winner per cycle gets a one-cycle grant.
// In the same cycle the winner's data goes onto the shared d bus, and its address
// becomes the one-hot register enable.
// Ports:
//   clk      clock, all state on posedge
//   rst      synchronous active-low reset
//   req      per-requester write request (held until granted)
//   wr_addr  requester i address in [i*AW +: AW]
//   wr_data  requester i data in [i*DW +: DW]
//   gnt      registered one-hot grant pulse
//   reg_en   registered one-hot register enable (zero when idle or out of range)
//   reg_d    registered write data to the bank
//   err      registered pulse: granted address was outside the bank
//   busy     combinational OR of req
module regbank_wr_arb #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic               err,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW-1:0]   last_ptr_reg;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [NREQ-1:0] elig;
  logic [2*NREQ-1:0] elig2;
  logic [PW:0]     pos;
  logic            found;
  logic [PW-1:0]   win;
  logic [AW-1:0]   sel_addr;
  logic            in_range;
  logic [NREG-1:0] en_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_split
      assign addr_arr[gi] = wr_addr[gi*AW +: AW];
      assign data_arr[gi] = wr_data[gi*DW +: DW];
    end
  endgenerate

  assign busy = |req;

  // The requester currently holding gnt is being acknowledged this cycle and may
  // still show req, so it is masked out to avoid a double grant.
  assign elig  = req & ~gnt;
  // Two copies side by side let the search run linearly from last_ptr+1 with wrap.
  assign elig2 = {elig, elig};

  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int j = 1; j <= NREQ; j++) begin
      pos = {1'b0, last_ptr_reg} + (PW+1)'(j);
      if (!found && elig2[pos]) begin
        found = 1'b1;
        win   = (pos >= NREQ_W) ? PW'(pos - NREQ_W) : PW'(pos);
      end
    end
  end

  assign sel_addr = addr_arr[win];
  assign in_range = (int'(sel_addr) < NREG);

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_en
      assign en_next[gi] = found && in_range && (int'(sel_addr) == gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt          <= '0;
      reg_en       <= '0;
      reg_d        <= '0;
      err          <= 1'b0;
      last_ptr_reg <= PW'(NREQ - 1);
    end else begin
      reg_en <= en_next;
      err    <= found && !in_range;
      if (found) begin
        gnt          <= NREQ'(1) << win;
        reg_d        <= data_arr[win];
        last_ptr_reg <= win;
      end else begin
        gnt <= '0;
      end
    end
  end

endmodule
